// File: rtl/snail_ram_arb_pkg.sv
// Shared constants and helpers for the SNAIL data-RAM arbiter.
// Owner ids, the idle strobe level and a one-hot decode used for gnt/rvld.
package snail_ram_arb_pkg;

    localparam logic ARB_M0       = 1'b0;
    localparam logic ARB_M1       = 1'b1;
    localparam logic RAM_STB_IDLE = 1'b1;

    // Turns an owner id plus valid into the per-master pulse vector.
    function automatic logic [1:0] id_to_onehot(input logic id, input logic vld);
        logic [1:0] oh;
        if (!vld) begin
            oh = 2'b00;
        end else if (id == ARB_M1) begin
            oh = 2'b10;
        end else begin
            oh = 2'b01;
        end
        return oh;
    endfunction

endpackage

// File: rtl/snail_rr_pick.sv
// Combinational 2-way round-robin picker; the last-winner register lives in the parent.
module snail_rr_pick
    import snail_ram_arb_pkg::*;
(
    input  logic [1:0] elig_i,
    input  logic       last_i,
    output logic       win_o,
    output logic       win_id_o
);

    // On a tie the master that did not win last time gets the slot.
    always_comb begin
        win_o    = 1'b0;
        win_id_o = last_i;
        case (elig_i)
            2'b01:   begin win_o = 1'b1; win_id_o = ARB_M0;  end
            2'b10:   begin win_o = 1'b1; win_id_o = ARB_M1;  end
            2'b11:   begin win_o = 1'b1; win_id_o = ~last_i; end
            default: begin win_o = 1'b0; win_id_o = last_i; end
        endcase
    end

endmodule

// File: rtl/snail_ram_arb.sv
// Round-robin arbiter sharing the SNAIL data RAM between the CPU (m0) and loader DMA (m1).
// Optional master lock for atomic read-modify-write: define SNAIL_ARB_LOCK_EN.
module snail_ram_arb
    import snail_ram_arb_pkg::*;
#(
    parameter int AW = 8,
    parameter int DW = 8
`ifdef SNAIL_ARB_LOCK_EN
    ,
    parameter int MAX_LOCK = 15
`endif
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          m0_req_i,
    input  logic          m0_we_i,
    input  logic [AW-1:0] m0_addr_i,
    input  logic [DW-1:0] m0_wdat_i,
    output logic          m0_gnt_o,
    output logic [DW-1:0] m0_rdat_o,
    output logic          m0_rvld_o,
    input  logic          m1_req_i,
    input  logic          m1_we_i,
    input  logic [AW-1:0] m1_addr_i,
    input  logic [DW-1:0] m1_wdat_i,
    output logic          m1_gnt_o,
    output logic [DW-1:0] m1_rdat_o,
    output logic          m1_rvld_o,
`ifdef SNAIL_ARB_LOCK_EN
    input  logic          m0_lock_i,
    input  logic          m1_lock_i,
`endif
    output logic [AW-1:0] ram_addr_o,
    output logic [DW-1:0] ram_wdat_o,
    input  logic [DW-1:0] ram_rdat_i,
    output logic          ram_rd_n_o,
    output logic          ram_wr_n_o
);

    logic [1:0]    req_s;
    logic [1:0]    elig_s;
    logic [1:0]    lock_mask_s;
    logic          win_s;
    logic          win_id_s;
    logic          sel_we_s;
    logic [AW-1:0] sel_addr_s;
    logic [DW-1:0] sel_wdat_s;

    logic [AW-1:0] ram_addr_q, ram_addr_d;
    logic [DW-1:0] ram_wdat_q, ram_wdat_d;
    logic          ram_rd_n_q, ram_rd_n_d;
    logic          ram_wr_n_q, ram_wr_n_d;
    logic [1:0]    gnt_q, gnt_d;
    logic [1:0]    rvld_q, rvld_d;
    logic          rd_vld_q, rd_vld_d;
    logic          rd_id_q, rd_id_d;
    logic          last_q, last_d;

    assign req_s  = {m1_req_i, m0_req_i};
    // A master in its gnt cycle is masked so a held request is not issued twice.
    assign elig_s = req_s & ~gnt_q & lock_mask_s;

    snail_rr_pick u_pick (
        .elig_i   (elig_s),
        .last_i   (last_q),
        .win_o    (win_s),
        .win_id_o (win_id_s)
    );

`ifdef SNAIL_ARB_LOCK_EN
    localparam int CW = $clog2(MAX_LOCK + 1);
    localparam logic [CW-1:0] LOCK_SAT = CW'(MAX_LOCK);

    logic [1:0]    lock_in_s;
    logic          lock_excl_s;
    logic          lock_act_q, lock_act_d;
    logic          lock_own_q, lock_own_d;
    logic [CW-1:0] lock_cnt_q, lock_cnt_d;

    assign lock_in_s = {m1_lock_i, m0_lock_i};

    // Exclusive eligibility while the owner keeps lock high and is below the grant limit.
    always_comb begin
        lock_excl_s = lock_act_q & lock_in_s[lock_own_q] & (lock_cnt_q != LOCK_SAT);
        if (lock_excl_s) begin
            lock_mask_s = id_to_onehot(lock_own_q, 1'b1);
        end else begin
            lock_mask_s = 2'b11;
        end
    end

    // A saturated or dropped lock releases on the next win, giving the other side an arbitration.
    always_comb begin
        lock_act_d = lock_act_q;
        lock_own_d = lock_own_q;
        lock_cnt_d = lock_cnt_q;
        if (win_s) begin
            if (lock_act_q && !lock_excl_s) begin
                lock_act_d = 1'b0;
                lock_cnt_d = {CW{1'b0}};
            end else if (lock_in_s[win_id_s]) begin
                if (lock_excl_s) begin
                    lock_cnt_d = lock_cnt_q + {{(CW-1){1'b0}}, 1'b1};
                end else begin
                    lock_act_d = 1'b1;
                    lock_own_d = win_id_s;
                    lock_cnt_d = {{(CW-1){1'b0}}, 1'b1};
                end
            end else begin
                lock_act_d = 1'b0;
                lock_cnt_d = {CW{1'b0}};
            end
        end else if (lock_act_q && !lock_in_s[lock_own_q]) begin
            lock_act_d = 1'b0;
            lock_cnt_d = {CW{1'b0}};
        end else begin
            lock_act_d = lock_act_q;
        end
    end

    // Lock state registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            lock_act_q <= 1'b0;
            lock_own_q <= ARB_M0;
            lock_cnt_q <= {CW{1'b0}};
        end else begin
            lock_act_q <= lock_act_d;
            lock_own_q <= lock_own_d;
            lock_cnt_q <= lock_cnt_d;
        end
    end
`else
    assign lock_mask_s = 2'b11;
`endif

    // Winner's command mux.
    always_comb begin
        if (win_id_s == ARB_M1) begin
            sel_we_s   = m1_we_i;
            sel_addr_s = m1_addr_i;
            sel_wdat_s = m1_wdat_i;
        end else begin
            sel_we_s   = m0_we_i;
            sel_addr_s = m0_addr_i;
            sel_wdat_s = m0_wdat_i;
        end
    end

    // Next RAM command, grant pulses and the read-owner pipe.
    always_comb begin
        ram_addr_d = ram_addr_q;
        ram_wdat_d = ram_wdat_q;
        ram_rd_n_d = RAM_STB_IDLE;
        ram_wr_n_d = RAM_STB_IDLE;
        gnt_d      = 2'b00;
        rd_vld_d   = 1'b0;
        rd_id_d    = rd_id_q;
        last_d     = last_q;
        rvld_d     = id_to_onehot(rd_id_q, rd_vld_q);
        if (win_s) begin
            ram_addr_d = sel_addr_s;
            ram_wdat_d = sel_wdat_s;
            if (sel_we_s) begin
                ram_wr_n_d = ~RAM_STB_IDLE;
            end else begin
                ram_rd_n_d = ~RAM_STB_IDLE;
            end
            gnt_d    = id_to_onehot(win_id_s, 1'b1);
            rd_vld_d = ~sel_we_s;
            rd_id_d  = win_id_s;
            last_d   = win_id_s;
        end else begin
            ram_rd_n_d = RAM_STB_IDLE;
            ram_wr_n_d = RAM_STB_IDLE;
        end
    end

    // Command, grant and response registers; last resets to m1 so m0 wins the first tie.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ram_addr_q <= {AW{1'b0}};
            ram_wdat_q <= {DW{1'b0}};
            ram_rd_n_q <= RAM_STB_IDLE;
            ram_wr_n_q <= RAM_STB_IDLE;
            gnt_q      <= 2'b00;
            rvld_q     <= 2'b00;
            rd_vld_q   <= 1'b0;
            rd_id_q    <= ARB_M0;
            last_q     <= ARB_M1;
        end else begin
            ram_addr_q <= ram_addr_d;
            ram_wdat_q <= ram_wdat_d;
            ram_rd_n_q <= ram_rd_n_d;
            ram_wr_n_q <= ram_wr_n_d;
            gnt_q      <= gnt_d;
            rvld_q     <= rvld_d;
            rd_vld_q   <= rd_vld_d;
            rd_id_q    <= rd_id_d;
            last_q     <= last_d;
        end
    end

    assign ram_addr_o = ram_addr_q;
    assign ram_wdat_o = ram_wdat_q;
    assign ram_rd_n_o = ram_rd_n_q;
    assign ram_wr_n_o = ram_wr_n_q;
    assign m0_gnt_o   = gnt_q[0];
    assign m1_gnt_o   = gnt_q[1];
    assign m0_rvld_o  = rvld_q[0];
    assign m1_rvld_o  = rvld_q[1];
    assign m0_rdat_o  = ram_rdat_i;
    assign m1_rdat_o  = ram_rdat_i;

endmodule

// File: tb/tb_snail_ram_arb.sv
// Scoreboard bench for snail_ram_arb with a behavioural RAM; lock scenario runs when SNAIL_ARB_LOCK_EN is defined.
module tb_snail_ram_arb;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       m0_req, m0_we, m0_gnt, m0_rvld;
    logic [7:0] m0_addr, m0_wdat, m0_rdat;
    logic       m1_req, m1_we, m1_gnt, m1_rvld;
    logic [7:0] m1_addr, m1_wdat, m1_rdat;
    logic [7:0] ram_addr, ram_wdat, ram_rdat;
    logic       ram_rd_n, ram_wr_n;
`ifdef SNAIL_ARB_LOCK_EN
    logic       m0_lock, m1_lock;
`endif

    typedef struct packed {logic we; logic [7:0] addr; logic [7:0] wdat; logic lock;} cmd_t;
    typedef struct packed {logic id; logic [7:0] data;} exp_t;

    cmd_t       q0[$];
    cmd_t       q1[$];
    exp_t       sb[$];
    logic [1:0] glog[$];
    logic       slog[$];
    logic [7:0] ram_mem [256];
    logic [7:0] ref_mem [256];
    int         checks = 0;
    int         errors = 0;

    always #5 clk = ~clk;

    snail_ram_arb dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .m0_req_i   (m0_req),
        .m0_we_i    (m0_we),
        .m0_addr_i  (m0_addr),
        .m0_wdat_i  (m0_wdat),
        .m0_gnt_o   (m0_gnt),
        .m0_rdat_o  (m0_rdat),
        .m0_rvld_o  (m0_rvld),
        .m1_req_i   (m1_req),
        .m1_we_i    (m1_we),
        .m1_addr_i  (m1_addr),
        .m1_wdat_i  (m1_wdat),
        .m1_gnt_o   (m1_gnt),
        .m1_rdat_o  (m1_rdat),
        .m1_rvld_o  (m1_rvld),
`ifdef SNAIL_ARB_LOCK_EN
        .m0_lock_i  (m0_lock),
        .m1_lock_i  (m1_lock),
`endif
        .ram_addr_o (ram_addr),
        .ram_wdat_o (ram_wdat),
        .ram_rdat_i (ram_rdat),
        .ram_rd_n_o (ram_rd_n),
        .ram_wr_n_o (ram_wr_n)
    );

    // Behavioural RAM: strobes sampled on clk, read data valid the following cycle.
    always @(posedge clk) begin
        if (!ram_wr_n) ram_mem[ram_addr] <= ram_wdat;
        if (!ram_rd_n) ram_rdat <= ram_mem[ram_addr];
    end

    task automatic apply_drive();
        m0_req  = (q0.size() > 0);
        m0_we   = m0_req ? q0[0].we   : 1'b0;
        m0_addr = m0_req ? q0[0].addr : 8'h00;
        m0_wdat = m0_req ? q0[0].wdat : 8'h00;
        m1_req  = (q1.size() > 0);
        m1_we   = m1_req ? q1[0].we   : 1'b0;
        m1_addr = m1_req ? q1[0].addr : 8'h00;
        m1_wdat = m1_req ? q1[0].wdat : 8'h00;
`ifdef SNAIL_ARB_LOCK_EN
        m0_lock = m0_req ? q0[0].lock : 1'b0;
        m1_lock = m1_req ? q1[0].lock : 1'b0;
`endif
    endtask

    task automatic account(input logic id, input cmd_t c);
        if (c.we) ref_mem[c.addr] = c.wdat;
        else      sb.push_back({id, ref_mem[c.addr]});
    endtask

    // One cycle: sample at negedge, score rvld, retire granted commands, present next ones.
    task automatic step();
        exp_t e;
        cmd_t c;
        @(negedge clk);
        glog.push_back({m1_gnt, m0_gnt});
        slog.push_back(!ram_rd_n || !ram_wr_n);
        if (m0_rvld || m1_rvld) begin
            checks++;
            if (m0_rvld && m1_rvld) begin
                errors++;
                $display("FAIL rvld_both: got m0=%b m1=%b expected one-hot", m0_rvld, m1_rvld);
            end else if (sb.size() == 0) begin
                errors++;
                $display("FAIL rvld_unexpected: got rvld m0=%b m1=%b expected none", m0_rvld, m1_rvld);
            end else begin
                e = sb.pop_front();
                if (m1_rvld !== e.id || m0_rdat !== e.data || m1_rdat !== e.data) begin
                    errors++;
                    $display("FAIL rvld_data: got owner=%0d rdat=%h/%h expected owner=%0d rdat=%h",
                             m1_rvld, m0_rdat, m1_rdat, e.id, e.data);
                end
            end
        end
        if (m0_gnt || m1_gnt) begin
            checks++;
            if ((m0_gnt && m1_gnt) || (m0_gnt && q0.size() == 0) || (m1_gnt && q1.size() == 0)) begin
                errors++;
                $display("FAIL gnt_valid: got gnt=%b%b expected single grant to a requester", m1_gnt, m0_gnt);
            end else if (m0_gnt) begin
                c = q0.pop_front();
                account(1'b0, c);
            end else begin
                c = q1.pop_front();
                account(1'b1, c);
            end
        end
        apply_drive();
    endtask

    task automatic run_until_idle(input int budget, input string name);
        int n = 0;
        while ((q0.size() > 0 || q1.size() > 0) && n < budget) begin
            step();
            n++;
        end
        checks++;
        if (q0.size() > 0 || q1.size() > 0) begin
            errors++;
            $display("FAIL %s_timeout: got pending=%0d/%0d expected 0/0", name, q0.size(), q1.size());
            q0.delete();
            q1.delete();
            apply_drive();
        end
        repeat (3) step();
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        q0.push_back({1'b1, 8'h10, 8'h41, 1'b0});
        q1.push_back({1'b1, 8'h11, 8'h99, 1'b0});
        apply_drive();
        repeat (3) step();
        checks++;
        if (ram_rd_n !== 1'b1 || ram_wr_n !== 1'b1 || ram_addr !== 8'h00 || ram_wdat !== 8'h00) begin
            errors++;
            $display("FAIL reset_ram: got rd_n=%b wr_n=%b addr=%h wdat=%h expected 1 1 00 00",
                     ram_rd_n, ram_wr_n, ram_addr, ram_wdat);
        end
        checks++;
        if ({m1_gnt, m0_gnt, m1_rvld, m0_rvld} !== 4'b0000) begin
            errors++;
            $display("FAIL reset_pulses: got %b expected 0000", {m1_gnt, m0_gnt, m1_rvld, m0_rvld});
        end
        rst_n = 1'b1;
        step();
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || ram_wr_n !== 1'b0 || ram_addr !== 8'h10 || ram_wdat !== 8'h41) begin
            errors++;
            $display("FAIL reset_first_m0: got gnt=%b%b wr_n=%b addr=%h wdat=%h expected 01 0 10 41",
                     m1_gnt, m0_gnt, ram_wr_n, ram_addr, ram_wdat);
        end
        step();
        checks++;
        if (m1_gnt !== 1'b1 || ram_addr !== 8'h11) begin
            errors++;
            $display("FAIL reset_second_m1: got m1_gnt=%b addr=%h expected 1 11", m1_gnt, ram_addr);
        end
        repeat (2) step();
    endtask

    task automatic test_read();
        q0.push_back({1'b0, 8'h10, 8'h00, 1'b0});
        apply_drive();
        step();
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0 || ram_rd_n !== 1'b0 || ram_wr_n !== 1'b1 || ram_addr !== 8'h10) begin
            errors++;
            $display("FAIL read_issue: got gnt=%b%b rd_n=%b wr_n=%b addr=%h expected 01 0 1 10",
                     m1_gnt, m0_gnt, ram_rd_n, ram_wr_n, ram_addr);
        end
        step();
        checks++;
        if (m0_rvld !== 1'b1 || m1_rvld !== 1'b0 || m0_rdat !== 8'h41) begin
            errors++;
            $display("FAIL read_return: got rvld=%b%b rdat=%h expected 01 41", m1_rvld, m0_rvld, m0_rdat);
        end
        step();
    endtask

    task automatic test_write();
        q1.push_back({1'b1, 8'h20, 8'h5A, 1'b0});
        apply_drive();
        step();
        checks++;
        if (m1_gnt !== 1'b1 || ram_wr_n !== 1'b0 || ram_rd_n !== 1'b1 || ram_addr !== 8'h20 || ram_wdat !== 8'h5A) begin
            errors++;
            $display("FAIL write_issue: got m1_gnt=%b wr_n=%b rd_n=%b addr=%h wdat=%h expected 1 0 1 20 5a",
                     m1_gnt, ram_wr_n, ram_rd_n, ram_addr, ram_wdat);
        end
        step();
        checks++;
        if (ram_wr_n !== 1'b1 || m0_rvld !== 1'b0 || m1_rvld !== 1'b0) begin
            errors++;
            $display("FAIL write_one_cycle: got wr_n=%b rvld=%b%b expected 1 00", ram_wr_n, m1_rvld, m0_rvld);
        end
        step();
        checks++;
        if (m0_rvld !== 1'b0 || m1_rvld !== 1'b0) begin
            errors++;
            $display("FAIL write_no_rvld: got rvld=%b%b expected 00", m1_rvld, m0_rvld);
        end
        q0.push_back({1'b0, 8'h20, 8'h00, 1'b0});
        apply_drive();
        step();
        step();
        checks++;
        if (m0_rvld !== 1'b1 || m0_rdat !== 8'h5A) begin
            errors++;
            $display("FAIL write_readback: got rvld=%b rdat=%h expected 1 5a", m0_rvld, m0_rdat);
        end
        step();
    endtask

    task automatic test_back_to_back();
        int f = -1;
        int bad = 0;
        for (int i = 0; i < 3; i++) begin
            q1.push_back({1'b1, 8'h40 + 8'(i), 8'($urandom_range(0, 255)), 1'b0});
            q1.push_back({1'b0, (i == 0) ? 8'h20 : (i == 1) ? 8'h11 : 8'h10, 8'h00, 1'b0});
        end
        q0.push_back({1'b0, 8'h10, 8'h00, 1'b0});
        q0.push_back({1'b0, 8'h11, 8'h00, 1'b0});
        q0.push_back({1'b0, 8'h20, 8'h00, 1'b0});
        q0.push_back({1'b0, 8'h40, 8'h00, 1'b0});
        q0.push_back({1'b0, 8'h41, 8'h00, 1'b0});
        q0.push_back({1'b0, 8'h42, 8'h00, 1'b0});
        glog.delete();
        slog.delete();
        apply_drive();
        run_until_idle(40, "b2b");
        for (int k = 0; k < glog.size(); k++) begin
            if (f < 0 && glog[k] != 2'b00) f = k;
        end
        checks++;
        if (f < 0 || f + 12 > glog.size()) begin
            errors++;
            $display("FAIL b2b_window: got first=%0d log=%0d expected 12 grant cycles", f, glog.size());
        end else begin
            for (int k = f; k < f + 12; k++) begin
                if (!(glog[k] == 2'b01 || glog[k] == 2'b10) || !slog[k]) bad++;
                if (k > f && glog[k] == glog[k-1]) bad++;
            end
            if (bad != 0) begin
                errors++;
                $display("FAIL b2b_alternate: got %0d bad cycles expected 0", bad);
            end
        end
    endtask

    task automatic test_hold_req();
        int pos[$];
        for (int i = 0; i < 3; i++) q0.push_back({1'b0, 8'h10, 8'h00, 1'b0});
        glog.delete();
        apply_drive();
        run_until_idle(20, "hold");
        for (int k = 0; k < glog.size(); k++) begin
            if (glog[k] == 2'b01) pos.push_back(k);
        end
        checks++;
        if (pos.size() != 3 || pos[1] - pos[0] != 2 || pos[2] - pos[1] != 2) begin
            errors++;
            $display("FAIL hold_spacing: got %0d grants gaps=%0d,%0d expected 3 grants gaps 2,2",
                     pos.size(), (pos.size() > 1) ? pos[1] - pos[0] : -1, (pos.size() > 2) ? pos[2] - pos[1] : -1);
        end
    endtask

    task automatic test_drop_req();
        // last is m0 here, so the tie goes to m1 and m0 loses then withdraws.
        q0.push_back({1'b0, 8'h11, 8'h00, 1'b0});
        q1.push_back({1'b0, 8'h20, 8'h77, 1'b0});
        apply_drive();
        step();
        checks++;
        if (m1_gnt !== 1'b1 || m0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL drop_tie: got gnt=%b%b expected 10", m1_gnt, m0_gnt);
        end
        q0.delete();
        apply_drive();
        step();
        checks++;
        if (m0_gnt !== 1'b0 || m1_gnt !== 1'b0 || ram_rd_n !== 1'b1 || ram_wr_n !== 1'b1 ||
            ram_addr !== 8'h20 || ram_wdat !== 8'h77) begin
            errors++;
            $display("FAIL drop_idle: got gnt=%b%b rd_n=%b wr_n=%b addr=%h wdat=%h expected 00 1 1 20 77",
                     m1_gnt, m0_gnt, ram_rd_n, ram_wr_n, ram_addr, ram_wdat);
        end
        q0.push_back({1'b0, 8'h10, 8'h00, 1'b0});
        q1.push_back({1'b0, 8'h11, 8'h00, 1'b0});
        apply_drive();
        step();
        checks++;
        if (m0_gnt !== 1'b1 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL drop_last: got gnt=%b%b expected 01", m1_gnt, m0_gnt);
        end
        run_until_idle(10, "drop");
    endtask

    task automatic test_reset_mid();
        q0.push_back({1'b0, 8'h10, 8'h00, 1'b0});
        apply_drive();
        step();
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (ram_rd_n !== 1'b1 || m0_gnt !== 1'b0) begin
            errors++;
            $display("FAIL midrst_async: got rd_n=%b gnt=%b expected 1 0", ram_rd_n, m0_gnt);
        end
        q0.delete();
        q1.delete();
        sb.delete();
        apply_drive();
        repeat (2) step();
        rst_n = 1'b1;
        repeat (2) step();
        checks++;
        if (m0_rvld !== 1'b0 || m1_rvld !== 1'b0 || m0_gnt !== 1'b0 || m1_gnt !== 1'b0) begin
            errors++;
            $display("FAIL midrst_quiet: got rvld=%b%b gnt=%b%b expected 00 00", m1_rvld, m0_rvld, m1_gnt, m0_gnt);
        end
    endtask

`ifdef SNAIL_ARB_LOCK_EN
    task automatic test_lock();
        int m0pos[$];
        int run = 0;
        logic [1:0] g[$];
        for (int i = 0; i < 3; i++) q0.push_back({1'b0, 8'h10, 8'h00, 1'b0});
        for (int i = 0; i < 40; i++) q1.push_back({1'b0, 8'h11, 8'h00, 1'b1});
        glog.delete();
        apply_drive();
        for (int n = 0; n < 200 && q0.size() > 0; n++) step();
        q1.delete();
        run_until_idle(5, "lock");
        for (int k = 0; k < glog.size(); k++) begin
            if (glog[k] != 2'b00) g.push_back(glog[k]);
        end
        for (int k = 0; k < g.size(); k++) begin
            if (g[k] == 2'b01) m0pos.push_back(k);
        end
        checks++;
        if (m0pos.size() < 2) begin
            errors++;
            $display("FAIL lock_m0_grants: got %0d expected >=2", m0pos.size());
        end else begin
            run = m0pos[1] - m0pos[0] - 1;
            if (run != 15) begin
                errors++;
                $display("FAIL lock_run: got %0d m1 grants between m0 grants expected 15", run);
            end
        end
    endtask
`endif

    initial begin
        test_reset();
        test_read();
        test_write();
        test_back_to_back();
        test_hold_req();
        test_drop_req();
        test_reset_mid();
`ifdef SNAIL_ARB_LOCK_EN
        test_lock();
`endif
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL sb_drain: got %0d outstanding reads expected 0", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
